// File: rtl/sort_pkg.sv
// Shared types and helpers for the oversampling sorter controller.
package sort_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      SORT,
      CAP,
      OUT
   } sort_state_t;

   // Width needed to hold a count of 0..n.
   function automatic int cw_f(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/therm2bin.sv
// Thermometer-to-binary decoder: popcount of the word plus a flag for any
// word that is not a clean run of ones starting at the LSB.
module therm2bin
   import sort_pkg::*;
#(
   parameter int N = 16,
   localparam int CW = cw_f(N)
) (
   input  logic [N-1:0]  word,
   output logic [CW-1:0] count,
   output logic          bubble_err
);

   logic [N:0] one;
   logic [N:0] mask;

   always_comb begin
      count = '0;
      for (int i = 0; i < N; i++) begin
         count = count + CW'(word[i]);
      end
   end

   // One bit wider than the word so that count == N still yields all ones.
   always_comb begin
      one        = (N+1)'(1);
      mask       = (one << count) - one;
      bubble_err = (word != mask[N-1:0]);
   end

endmodule

// File: rtl/sort_ctrl.sv
// Sorter sequencer: precharge/settle schedule on P, capture of the sorted
// word, and ones-count/bubble result offered on a valid/ready handshake.
module sort_ctrl
   import sort_pkg::*;
#(
   parameter int SAMPLES = 2,
   parameter int OSF     = 8,
   parameter int PRE_CYC = 2,
   parameter int SETTLE  = 4,
   localparam int N      = SAMPLES * OSF,
   localparam int CW     = cw_f(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          P,
   input  logic [N-1:0]  sorted_in,
   output logic          busy,
   output logic [CW-1:0] count,
   output logic          bubble_err,
   output logic          valid,
   input  logic          ready
);

   localparam int PMAX = (PRE_CYC > SETTLE) ? PRE_CYC : SETTLE;
   localparam int PW   = $clog2(PMAX + 1);

   sort_state_t   state, state_nx;
   logic [PW-1:0] phase, phase_nx;
   logic          cap_en, out_en;
   logic [N-1:0]  capture;
   logic [CW-1:0] dec_count;
   logic          dec_err;

   therm2bin #(.N(N)) u_t2b (
      .word       (capture),
      .count      (dec_count),
      .bubble_err (dec_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= '0;
         capture    <= '0;
         count      <= '0;
         bubble_err <= 1'b0;
         P          <= 1'b1;
         busy       <= 1'b0;
         valid      <= 1'b0;
      end else begin
         state <= state_nx;
         phase <= phase_nx;
         if (cap_en) capture <= sorted_in;
         if (out_en) begin
            count      <= dec_count;
            bubble_err <= dec_err;
         end
         // Outputs decoded from the next state so they change with the state.
         P     <= !(state_nx == SORT || state_nx == CAP);
         busy  <= (state_nx != IDLE);
         valid <= (state_nx == OUT);
      end
   end

   always_comb begin
      state_nx = state;
      phase_nx = phase;
      cap_en   = 1'b0;
      out_en   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = PRE;
               phase_nx = PW'(PRE_CYC);
            end
         end
         PRE: begin
            if (phase == PW'(1)) begin
               state_nx = SORT;
               phase_nx = PW'(SETTLE);
            end else begin
               phase_nx = phase - PW'(1);
            end
         end
         SORT: begin
            if (phase == PW'(1)) begin
               state_nx = CAP;
               cap_en   = 1'b1;
            end else begin
               phase_nx = phase - PW'(1);
            end
         end
         CAP: begin
            state_nx = OUT;
            out_en   = 1'b1;
         end
         OUT: begin
            // valid is always high here, so the handshake reduces to ready.
            if (ready) begin
               if (start) begin
                  state_nx = PRE;
                  phase_nx = PW'(PRE_CYC);
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sort_ctrl.sv
// Directed bench for sort_ctrl with default parameters.
module tb_sort_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        P;
   logic [15:0] sorted_in;
   logic        busy;
   logic [4:0]  count;
   logic        bubble_err;
   logic        valid;
   logic        ready;

   int checks = 0;
   int errors = 0;

   sort_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .P          (P),
      .sorted_in  (sorted_in),
      .busy       (busy),
      .count      (count),
      .bubble_err (bubble_err),
      .valid      (valid),
      .ready      (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full conversion with ready=1; k is the number of edges since the start edge.
   task automatic run_conv(input logic [15:0] word, input logic [4:0] exp_cnt, input logic exp_err);
      sorted_in = word;
      ready     = 1'b1;
      start     = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         start = 1'b0;
         check("conv_P",     P,     (k >= 2 && k <= 6) ? 1'b0 : 1'b1);
         check("conv_valid", valid, (k == 7));
         check("conv_busy",  busy,  (k <= 7));
         if (k == 7) begin
            check("conv_count", count,      exp_cnt);
            check("conv_err",   bubble_err, exp_err);
         end
      end
   endtask

   initial begin
      int nvalid;
      rst = 1'b1; start = 1'b0; ready = 1'b0; sorted_in = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      check("rst_count", count, 0);
      check("rst_err",   bubble_err, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_P",     P,     1);
         check("idle_busy",  busy,  0);
         check("idle_valid", valid, 0);
      end

      run_conv(16'h00FF, 5'd8,  1'b0);
      run_conv(16'h00F7, 5'd7,  1'b1);
      run_conv(16'h0000, 5'd0,  1'b0);
      run_conv(16'hFFFF, 5'd16, 1'b0);
      run_conv(16'h8000, 5'd1,  1'b1);

      // Backpressure, then back-to-back restart on the accepting edge.
      sorted_in = 16'h0003; ready = 1'b0; start = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         check("bp_valid", valid, 1);
         check("bp_count", count, 2);
         check("bp_P",     P,     1);
      end
      sorted_in = 16'h003F; ready = 1'b1; start = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         start = 1'b0;
         check("b2b_busy",  busy,  (k <= 7));
         check("b2b_P",     P,     (k >= 2 && k <= 6) ? 1'b0 : 1'b1);
         check("b2b_valid", valid, (k == 7));
         if (k == 7) check("b2b_count", count, 6);
      end

      // start pulsed during SORT must not queue a second conversion.
      sorted_in = 16'h000F; start = 1'b1; nvalid = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         start = (k == 3);
         if (valid) begin
            nvalid++;
            check("ign_count", count, 4);
         end
      end
      check("ign_nvalid", nvalid, 1);
      check("ign_busy",   busy,   0);

      // Reset in SORT discards the conversion.
      sorted_in = 16'h00FF; start = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre_rst_P", P, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_P",     P,     1);
      check("mid_rst_valid", valid, 0);
      check("mid_rst_busy",  busy,  0);
      run_conv(16'h01FF, 5'd9, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
